// File: rtl/stdp_pkg.sv
// Shared widths, parameter defaults and saturation helper for the STDP synapse.
// Weight and trace values are unsigned; update arithmetic is carried in a wider signed type.
package stdp_pkg;

    localparam int unsigned WEIGHT_W = 8;
    localparam int unsigned TRACE_W  = 8;
    localparam int unsigned DELTA_W  = 10;

    localparam int W_INIT_DEF      = 64;
    localparam int W_MAX_DEF       = 127;
    localparam int W_MIN_DEF       = 0;
    localparam int TRACE_MAX_DEF   = 255;
    localparam int DECAY_SHIFT_DEF = 3;
    localparam int A_POS_SHIFT_DEF = 4;
    localparam int A_NEG_SHIFT_DEF = 5;

    typedef logic [WEIGHT_W-1:0]       weight_t;
    typedef logic [TRACE_W-1:0]        trace_t;
    typedef logic signed [DELTA_W-1:0] delta_t;

    // Clamp a signed intermediate weight into [lo, hi]; never wraps.
    function automatic weight_t sat_weight(input delta_t v, input int lo, input int hi);
        delta_t lo_s;
        delta_t hi_s;
        delta_t r;
        lo_s = delta_t'(lo);
        hi_s = delta_t'(hi);
        if (v > hi_s) begin
            r = hi_s;
        end else if (v < lo_s) begin
            r = lo_s;
        end else begin
            r = v;
        end
        return r[WEIGHT_W-1:0];
    endfunction

endpackage

// File: rtl/stdp_trace.sv
// Spike trace: reloads to TRACE_MAX on a spike, otherwise decays toward zero
// by trace>>DECAY_SHIFT, with a minimum step of 1 so the tail always reaches zero.
module stdp_trace
    import stdp_pkg::*;
#(
    parameter int TRACE_MAX   = TRACE_MAX_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   spike,
    output trace_t trace
);

    trace_t trace_q;
    trace_t trace_d;
    trace_t decay;

    always_comb begin
        decay = trace_q >> DECAY_SHIFT;
        if (trace_q != '0 && decay == '0) begin
            decay = trace_t'(1);
        end
        if (spike) begin
            trace_d = trace_t'(TRACE_MAX);
        end else begin
            trace_d = trace_q - decay;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign trace = trace_q;

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: pre/post traces, saturating weight update and a
// registered synaptic current that carries the pre-edge weight for one cycle per pre spike.
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter int W_INIT      = W_INIT_DEF,
    parameter int W_MAX       = W_MAX_DEF,
    parameter int W_MIN       = W_MIN_DEF,
    parameter int TRACE_MAX   = TRACE_MAX_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
    parameter int A_POS_SHIFT = A_POS_SHIFT_DEF,
    parameter int A_NEG_SHIFT = A_NEG_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pre_spike,
    input  logic                post_spike,
    input  logic                learn_en,
    output logic [WEIGHT_W-1:0] current,
    output logic [WEIGHT_W-1:0] weight,
    output logic [TRACE_W-1:0]  pre_trace,
    output logic [TRACE_W-1:0]  post_trace,
    output logic                ltp,
    output logic                ltd
);

    trace_t  pre_trace_q;
    trace_t  post_trace_q;

    weight_t weight_q;
    weight_t weight_d;
    weight_t current_q;
    weight_t current_d;
    logic    ltp_q;
    logic    ltp_d;
    logic    ltd_q;
    logic    ltd_d;

    trace_t  pos_term;
    trace_t  neg_term;
    delta_t  weight_ext;
    delta_t  pos_ext;
    delta_t  neg_ext;
    delta_t  weight_sum;

    stdp_trace #(
        .TRACE_MAX   (TRACE_MAX),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_pre_trace (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (pre_spike),
        .trace (pre_trace_q)
    );

    stdp_trace #(
        .TRACE_MAX   (TRACE_MAX),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_post_trace (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (post_spike),
        .trace (post_trace_q)
    );

    // Both terms use the traces held before this edge, so a simultaneous
    // pre/post spike nets the two contributions in a single update.
    always_comb begin
        pos_term   = '0;
        neg_term   = '0;
        if (learn_en && post_spike) begin
            pos_term = pre_trace_q >> A_POS_SHIFT;
        end
        if (learn_en && pre_spike) begin
            neg_term = post_trace_q >> A_NEG_SHIFT;
        end

        weight_ext = delta_t'({{(DELTA_W - WEIGHT_W){1'b0}}, weight_q});
        pos_ext    = delta_t'({{(DELTA_W - TRACE_W){1'b0}}, pos_term});
        neg_ext    = delta_t'({{(DELTA_W - TRACE_W){1'b0}}, neg_term});
        weight_sum = weight_ext + pos_ext - neg_ext;

        weight_d = weight_q;
        if (learn_en) begin
            weight_d = sat_weight(weight_sum, W_MIN, W_MAX);
        end

        ltp_d     = (pos_term != '0);
        ltd_d     = (neg_term != '0);
        current_d = pre_spike ? weight_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_q  <= weight_t'(W_INIT);
            current_q <= '0;
            ltp_q     <= 1'b0;
            ltd_q     <= 1'b0;
        end else begin
            weight_q  <= weight_d;
            current_q <= current_d;
            ltp_q     <= ltp_d;
            ltd_q     <= ltd_d;
        end
    end

    assign current    = current_q;
    assign weight     = weight_q;
    assign pre_trace  = pre_trace_q;
    assign post_trace = post_trace_q;
    assign ltp        = ltp_q;
    assign ltd        = ltd_q;

endmodule

// File: doc/stdp_synapse.md
STDP_SYNAPSE -- requirements
Module: stdp_synapse

Interface
REQ-001 SHALL have parameter W_INIT, default 64, weight value loaded at reset.
REQ-002 SHALL have parameter W_MAX, default 127, upper weight saturation bound.
REQ-003 SHALL have parameter W_MIN, default 0, lower weight saturation bound.
REQ-004 SHALL have parameter TRACE_MAX, default 255, trace value loaded on a spike.
REQ-005 SHALL have parameter DECAY_SHIFT, default 3, trace decay per cycle of trace>>DECAY_SHIFT.
REQ-006 SHALL have parameter A_POS_SHIFT, default 4, potentiation step of pre_trace>>A_POS_SHIFT.
REQ-007 SHALL have parameter A_NEG_SHIFT, default 5, depression step of post_trace>>A_NEG_SHIFT.
REQ-008 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-009 SHALL have ports: pre_spike in 1, presynaptic spike pulse; post_spike in 1, postsynaptic (neuron output) spike pulse; learn_en in 1, weight update enable.
REQ-010 SHALL have ports: current out 8, registered synaptic current for the neuron input; weight out 8, current synaptic weight.
REQ-011 SHALL have ports: pre_trace out 8, post_trace out 8 (trace state); ltp out 1, ltd out 1 (one-cycle update pulses).

Function
REQ-012 All inputs SHALL be sampled on the rising edge of clk; all outputs SHALL be registered.
REQ-013 Trace update per cycle: spike present -> trace <= TRACE_MAX (reload, no accumulation); else trace <= trace - d, d = trace>>DECAY_SHIFT, with d forced to 1 when trace != 0 and d == 0; trace == 0 stays 0.
REQ-014 pre_trace SHALL follow pre_spike and post_trace SHALL follow post_spike by REQ-013, independent of learn_en.
REQ-015 Potentiation: post_spike with learn_en=1 SHALL add pre_trace>>A_POS_SHIFT to the weight, using the pre_trace value held before this edge.
REQ-016 Depression: pre_spike with learn_en=1 SHALL subtract post_trace>>A_NEG_SHIFT from the weight, using the post_trace value held before this edge.
REQ-017 Simultaneous pre_spike and post_spike SHALL apply both terms in one cycle as net delta, from pre-edge traces.
REQ-018 Weight arithmetic SHALL be at least 10-bit signed; the result SHALL saturate to [W_MIN, W_MAX], with no wrap-around.
REQ-019 learn_en=0 SHALL freeze the weight; ltp and ltd SHALL stay 0.
REQ-020 ltp SHALL pulse for one cycle when a potentiation term is nonzero; ltd SHALL pulse for one cycle when a depression term is nonzero; both MAY pulse together.
REQ-021 current SHALL equal the pre-edge weight in the cycle after pre_spike, and 0 otherwise (1-cycle latency, weight change not visible until the next spike).
REQ-022 Back-to-back pre_spike cycles SHALL produce current on each following cycle with no gap.

Reset
REQ-023 rst_n=0 at an edge SHALL set weight=W_INIT, pre_trace=0, post_trace=0, current=0, ltp=0, ltd=0, overriding all inputs.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight update; the first post-reset edge SHALL process inputs normally.

Structure
REQ-025 Parameter defaults and widths (weight width 8, trace width 8, internal delta width 10) SHALL reside in shared package stdp_pkg.
REQ-026 Trace reload/decay SHALL be sub-module stdp_trace (spike in, trace out), instantiated twice.
REQ-027 stdp_synapse current SHALL connect directly to the LIF neuron current input.

Verification
REQ-028 Reset then idle 5 cycles -> weight=64, traces=0, current=0, ltp=ltd=0.
REQ-029 Single pre_spike at edge N -> pre_trace=255 after N, then 224, 196, 172; current=64 for exactly one cycle after N.
REQ-030 pre_spike at N, post_spike at N+1, learn_en=1 -> weight 64->79 after N+1, ltp pulses once.
REQ-031 post_spike at N, pre_spike at N+1, learn_en=1 -> weight 64->57 after N+1, ltd pulses once, current=64 after N+1.
REQ-032 Saturation: 2 pre->post pairings from weight 120 -> 127 and held; learn_en=0 pairing -> weight unchanged, no pulses.
REQ-033 Decay tail: pre_trace=7 idle -> 6,5,...,0 and holds 0; simultaneous pre/post with zero traces -> weight unchanged, both traces 255.
